// File: rtl/sevenseg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package sevenseg_pkg;

  localparam int unsigned NIB_W     = 4;
  localparam int unsigned MAX_DIGITS = 8;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // All digit lines inactive for the given polarity.
  function automatic logic [MAX_DIGITS-1:0] digit_off(input logic active_low);
    return active_low ? {MAX_DIGITS{1'b1}} : {MAX_DIGITS{1'b0}};
  endfunction

  // Only line idx active for the given polarity.
  function automatic logic [MAX_DIGITS-1:0] digit_on(input logic active_low,
                                                     input logic [2:0] idx);
    logic [MAX_DIGITS-1:0] one_hot;
    one_hot = MAX_DIGITS'(1) << idx;
    return active_low ? ~one_hot : one_hot;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot counter and digit index for the display scan.
module scan_timer #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SLOT_CYCLES  = 12000,
  parameter int unsigned BLANK_CYCLES = 600,
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] idx,
  output logic             blank_end,
  output logic             slot_end,
  output logic             frame_end
);

  localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  // Terminal-count decodes; blank_end never fires when there is no blank phase.
  assign slot_end  = (cnt == CNT_W'(SLOT_CYCLES - 1));
  assign blank_end = (BLANK_CYCLES != 0) && (cnt == CNT_W'(BLANK_CYCLES - 1));
  assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

  // Count cycles within a slot and step the digit index at each slot end.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed scan controller for an N-digit seven-segment display.
// Host values land in a pending register and are committed to the display
// shadow only at frame boundaries, so a frame never mixes two values.
module sevenseg_scanner
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned SLOT_CYCLES      = 12000,
  parameter int unsigned BLANK_CYCLES     = 600,
  parameter int unsigned DIGIT_ACTIVE_LOW = 1,
  parameter int unsigned LZ_BLANK         = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NIB_W*NUM_DIGITS-1:0] value,
  input  logic                        load,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  output logic [NIB_W-1:0]            nibble_out,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic                        dp_out,
  output logic                        frame_done
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned VAL_W = NIB_W * NUM_DIGITS;
  localparam logic        ACT_LOW = (DIGIT_ACTIVE_LOW != 0);

  logic [IDX_W-1:0]      idx;
  logic                  blank_end;
  logic                  slot_end;
  logic                  frame_end;

  logic [VAL_W-1:0]      pend_val;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pend_valid;
  logic [VAL_W-1:0]      shadow_val;
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic                  shadow_valid;

  logic [NIB_W-1:0]      nib_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] suppress;
  logic                  zero_above;

  state_t                state;
  state_t                state_nxt;
  logic [NUM_DIGITS-1:0] digit_en_d;
  logic [NIB_W-1:0]      nibble_d;
  logic                  dp_d;
  logic                  frame_done_d;

  scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SLOT_CYCLES (SLOT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx),
    .blank_end(blank_end),
    .slot_end (slot_end),
    .frame_end(frame_end)
  );

  // Capture host writes into pending; commit to shadow at the frame boundary.
  // shadow_valid keeps the display dark until the first value is committed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val     <= '0;
      pend_dp      <= '0;
      pend_valid   <= 1'b0;
      shadow_val   <= '0;
      shadow_dp    <= '0;
      shadow_valid <= 1'b0;
    end else begin
      if (frame_end && pend_valid) begin
        shadow_val   <= pend_val;
        shadow_dp    <= pend_dp;
        shadow_valid <= 1'b1;
        pend_valid   <= 1'b0;
      end
      if (load) begin
        pend_val   <= value;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end
    end
  end

  // Split the shadow into nibbles and flag leading zeros above digit 0.
  always_comb begin
    suppress   = '0;
    zero_above = 1'b1;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      nib_arr[k] = shadow_val[k*NIB_W +: NIB_W];
    end
    for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
      zero_above  = zero_above && (nib_arr[k] == '0);
      suppress[k] = (LZ_BLANK != 0) && zero_above;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= BLANK;
    else     state <= state_nxt;
  end

  // Next state and next output values for the current slot.
  always_comb begin
    state_nxt    = state;
    digit_en_d   = NUM_DIGITS'(digit_off(ACT_LOW));
    nibble_d     = nib_arr[idx];
    dp_d         = 1'b0;
    frame_done_d = frame_end;
    case (state)
      BLANK: begin
        if ((BLANK_CYCLES == 0) || blank_end) state_nxt = SHOW;
      end
      SHOW: begin
        if (shadow_valid && !suppress[idx]) begin
          digit_en_d = NUM_DIGITS'(digit_on(ACT_LOW, 3'(idx)));
          dp_d       = shadow_dp[idx];
        end
        if (slot_end && (BLANK_CYCLES != 0)) state_nxt = BLANK;
      end
      default: state_nxt = BLANK;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_en   <= NUM_DIGITS'(digit_off(ACT_LOW));
      nibble_out <= '0;
      dp_out     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      digit_en   <= digit_en_d;
      nibble_out <= nibble_d;
      dp_out     <= dp_d;
      frame_done <= frame_done_d;
    end
  end

endmodule
